serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial N-bit adder that wraps the team's existing 1-bit full adder cell (FA) with operand shift registers, a carry flip-flop and a control FSM. On a start request it captures two N-bit operands and a carry-in. It feeds one bit pair per clock into FA, LSB first, and registers the carry between bits. It then presents the N-bit sum and final carry with a one-cycle done pulse. It sits directly upstream of the FA datapath and is the sequential controller that turns the combinational 1-bit stage into a multi-bit adder.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request to begin an addition; sampled only in IDLE
a  input  WIDTH  operand A; sampled only when start is accepted
b  input  WIDTH  operand B; sampled only when start is accepted
c_in  input  1  carry into bit 0; sampled only when start is accepted
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse; s/c_out valid from this cycle on
s  output  WIDTH  registered sum
c_out  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high, takes priority over all other inputs.
- Reset values: state=IDLE, busy=0, done=0, s=0, c_out=0; internal shift registers, carry FF and bit counter cleared.
- States: IDLE, RUN, DONE (2-bit encoding; unused code -> IDLE next edge).
- IDLE: on an edge with start=1:
  - load a_sr<=a, b_sr<=b, carry<=c_in, cnt<=0, sum_sr<=0;
  - go to RUN.
  - start=0 stays in IDLE.
- RUN (busy=1): each edge:
  - FA inputs: a=a_sr[0], b=b_sr[0], c_in=carry.
  - sum_sr <= {FA.s, sum_sr[WIDTH-1:1]} (fills MSB-first, so after WIDTH shifts bit i is at position i).
  - carry <= FA.c_out.
  - a_sr, b_sr shift right by 1 (zero fill); cnt <= cnt+1.
  - When cnt==WIDTH-1 on the edge: s <= final sum_sr value including this bit, c_out <= this bit's FA.c_out, go to DONE.
  - RUN therefore lasts exactly WIDTH cycles.
- DONE: done=1, busy=0 for exactly one cycle; next edge -> IDLE unconditionally.
- Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH, i.e. WIDTH+1 cycles after start.
  - Minimum spacing between accepted starts: WIDTH+2 cycles. start is first re-sampled in the IDLE cycle after DONE.
- start while busy or in DONE: ignored, not queued; a, b, c_in changes during RUN have no effect.
- s/c_out change only at the RUN->DONE edge or on reset; they hold their last result through IDLE and through the next operation until it completes.
- Arithmetic: {c_out, s} = a + b + c_in, modulo 2^(WIDTH+1); no overflow flag.
- cnt width: clog2(WIDTH), minimum 1 bit. WIDTH=1: RUN lasts one cycle, done 2 cycles after start.
- Reset mid-operation (RUN or DONE): abort; outputs return to reset values the following cycle, no done pulse.
- Timing: FA gate path (XOR 6 + XOR 6 + AND 5 + OR 5 units) must settle within one clk period. Bench clock period >= 30 time units.

Test Plan:
- Reset: hold rst 2 cycles with start=1 -> busy=0, done=0, s=0x00, c_out=0; FSM stays in IDLE until rst falls.
- WIDTH=8, a=0x5A, b=0x3C, c_in=0, pulse start -> busy high 8 cycles, done pulse at cycle 9, s=0x96, c_out=0.
- Wrap/carry chain: a=0xFF, b=0x01, c_in=0 -> s=0x00, c_out=1. Repeat with a=0xFF, b=0x00, c_in=1 -> s=0x00, c_out=1. Repeat with a=0xFF, b=0xFF, c_in=1 -> s=0xFF, c_out=1.
- Ignored start: launch 0x10+0x20, reassert start with a=0xAA, b=0x55 at RUN cycles 3 and in DONE, changing a/b mid-run -> single done, s=0x30, c_out=0, busy never restarts.
- Reset mid-op: launch 0x80+0x80, assert rst at RUN cycle 5 -> next cycle busy=0, s=0, c_out=0, no done pulse. Then a fresh 0x01+0x02 run yields s=0x03.
- Back-to-back plus random sweep: start held high continuously -> operations accepted every 10 cycles (WIDTH+2). 1000 random {a, b, c_in} checked against a+b+c_in, also run at WIDTH=1 (exhaustive 8 cases, 2-cycle latency).

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: the requester drives start and operands,
// the adder returns busy, a one-cycle done pulse and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, s, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, s, c_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder around a 1-bit full adder cell: one bit per clock, LSB first.
// done pulses WIDTH+1 cycles after start; start is ignored (not queued) outside IDLE.

module fa (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  logic p;

  // Worst path is XOR -> XOR (sum) or XOR -> AND -> OR (carry); it must settle in one clk period.
  assign p     = a ^ b;
  assign s     = p ^ c_in;
  assign c_out = (a & b) | (p & c_in);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  fa u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c_in  (carry),
    .s     (fa_s),
    .c_out (fa_c)
  );

  // Sum bits enter at the MSB so that after WIDTH shifts bit i sits at position i.
  if (WIDTH == 1) begin : g_sum_w1
    assign sum_next = fa_s;
  end else begin : g_sum_wn
    assign sum_next = {fa_s, sum_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.s     <= '0;
      bus.c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            carry    <= bus.c_in;
            cnt      <= '0;
            sum_sr   <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_sr <= sum_next;
          carry  <= fa_c;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            bus.s     <= sum_next;
            bus.c_out <= fa_c;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed checks of serial_adder at WIDTH=8 and WIDTH=1 against plain a+b+c_in.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #15 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic [7:0] last_s8;
  logic       last_c8;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called with the adder idle; returns sampled in the IDLE cycle after DONE.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] exp;
    int lat, bcnt;
    exp = 9'(a) + 9'(b) + 9'(ci);
    if8.a = a; if8.b = b; if8.c_in = ci; if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    chk("w8_busy_at_start", if8.busy, 1);
    chk("w8_result_held", {if8.c_out, if8.s}, {last_c8, last_s8});
    lat = 0; bcnt = 0;
    while (!if8.done && lat < 30) begin
      if (if8.busy) bcnt++;
      if8.a = 8'($urandom); if8.b = 8'($urandom);
      step();
      lat++;
    end
    chk("w8_latency", lat, 8);
    chk("w8_busy_cycles", bcnt, 8);
    chk("w8_sum", if8.s, exp[7:0]);
    chk("w8_cout", if8.c_out, exp[8]);
    chk("w8_busy_in_done", if8.busy, 0);
    step();
    chk("w8_done_one_cycle", if8.done, 0);
    last_s8 = exp[7:0];
    last_c8 = exp[8];
  endtask

  task automatic run1(input logic a, input logic b, input logic ci);
    logic [1:0] exp;
    int lat;
    exp = 2'(a) + 2'(b) + 2'(ci);
    if1.a = a; if1.b = b; if1.c_in = ci; if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    chk("w1_busy_at_start", if1.busy, 1);
    lat = 0;
    while (!if1.done && lat < 10) begin
      step();
      lat++;
    end
    chk("w1_latency", lat, 1);
    chk("w1_sum", if1.s, exp[0]);
    chk("w1_cout", if1.c_out, exp[1]);
    step();
    chk("w1_done_one_cycle", if1.done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] exp;
    logic [7:0] na, nb;
    logic       nc;
    logic [2:0] v;
    int w, acc, prev_acc, dones, busies, done_at;

    if8.start = 1'b1; if8.a = 8'hA5; if8.b = 8'h5A; if8.c_in = 1'b1;
    if1.start = 1'b1; if1.a = 1'b1;  if1.b = 1'b1;  if1.c_in = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_busy", if8.busy, 0);
      chk("rst_done", if8.done, 0);
      chk("rst_s", if8.s, 0);
      chk("rst_cout", if8.c_out, 0);
      chk("rst_w1_busy", if1.busy, 0);
    end
    rst = 1'b0; if8.start = 1'b0; if1.start = 1'b0;
    step();
    chk("idle_after_rst", if8.busy, 0);
    last_s8 = 8'h00; last_c8 = 1'b0;

    run8(8'h5A, 8'h3C, 1'b0);
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'hFF, 8'h00, 1'b1);
    run8(8'hFF, 8'hFF, 1'b1);
    run8(8'h00, 8'h00, 1'b0);

    // Restart attempts during RUN and DONE must be ignored.
    if8.a = 8'h10; if8.b = 8'h20; if8.c_in = 1'b0; if8.start = 1'b1;
    step();
    dones = 0; busies = 0; done_at = -1;
    for (int i = 1; i <= 20; i++) begin
      if (if8.busy) busies++;
      if (if8.done) begin
        dones++;
        done_at = i;
        chk("ign_sum", if8.s, 8'h30);
        chk("ign_cout", if8.c_out, 0);
      end
      if (i == 3) begin
        if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55;
      end else if (i == 9) begin
        if8.start = 1'b1;
      end else begin
        if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom);
      end
      step();
    end
    chk("ign_done_count", dones, 1);
    chk("ign_done_at", done_at, 9);
    chk("ign_busy_cycles", busies, 8);
    last_s8 = 8'h30; last_c8 = 1'b0;

    // Reset in the middle of an operation aborts it without a done pulse.
    if8.a = 8'h80; if8.b = 8'h80; if8.c_in = 1'b0; if8.start = 1'b1;
    step();
    if8.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", if8.busy, 0);
    chk("abort_done", if8.done, 0);
    chk("abort_s", if8.s, 0);
    chk("abort_cout", if8.c_out, 0);
    dones = 0; busies = 0;
    for (int i = 0; i < 12; i++) begin
      if (if8.done) dones++;
      if (if8.busy) busies++;
      step();
    end
    chk("abort_no_done", dones, 0);
    chk("abort_stays_idle", busies, 0);
    last_s8 = 8'h00; last_c8 = 1'b0;
    run8(8'h01, 8'h02, 1'b0);

    // start held high: one accepted operation every WIDTH+2 cycles.
    na = 8'($urandom); nb = 8'($urandom); nc = 1'($urandom);
    if8.a = na; if8.b = nb; if8.c_in = nc; if8.start = 1'b1;
    prev_acc = 0;
    for (int k = 0; k < 1000; k++) begin
      w = 0;
      while (!if8.busy && w < 20) begin step(); w++; end
      chk("b2b_accept", if8.busy, 1);
      acc = cyc;
      if (k > 0) chk("b2b_spacing", acc - prev_acc, 10);
      prev_acc = acc;
      exp = 9'(na) + 9'(nb) + 9'(nc);
      na = 8'($urandom); nb = 8'($urandom); nc = 1'($urandom);
      if8.a = na; if8.b = nb; if8.c_in = nc;
      w = 0;
      while (!if8.done && w < 20) begin step(); w++; end
      chk("b2b_sum", if8.s, exp[7:0]);
      chk("b2b_cout", if8.c_out, exp[8]);
      step();
    end
    if8.start = 1'b0;
    step();
    step();

    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      run1(v[0], v[1], v[2]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
